video2ram_param: RTL and testbench

VIDEO2RAM_PARAM -- requirements
Module: video2ram_param

---
 rtl/video2ram_param.sv | 102 ++++++++++
 tb/tb_video2ram_param.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video2ram_param.sv
// Captures a rectangular window of the incoming raster into a ring buffer RAM.
// Writes land one clock after the capture cycle; the pointer restarts at every frame start.
module video2ram_param #(
    parameter int COLOR_BITS      = 8,
    parameter int ADDR_BITS       = 14,
    parameter int DEPTH           = 16384,
    parameter int H_CAPTURE_START = 126,
    parameter int H_CAPTURE_END   = 766,
    parameter int V_CAPTURE_START = 0,
    parameter int V_CAPTURE_END   = 480,
    parameter int FIELD_LINES     = 240,
    parameter int FIELD2_START    = 263,
    parameter int TRIGGER_LINE    = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COLOR_BITS-1:0]     R,
    input  logic [COLOR_BITS-1:0]     G,
    input  logic [COLOR_BITS-1:0]     B,
    input  logic [11:0]               counterX,
    input  logic [11:0]               counterY,
    input  logic                      line_doubler,
    input  logic                      hdecimate,
    output logic [3*COLOR_BITS-1:0]   wrdata,
    output logic [ADDR_BITS-1:0]      wraddr,
    output logic                      wren,
    output logic                      wrclock,
    output logic                      starttrigger,
    output logic                      overflow
);

    localparam int CNT_W = ADDR_BITS + 1;
    localparam logic HS_LSB = 1'(H_CAPTURE_START % 2);
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_OVF = CNT_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    int x;
    int y;
    logic v_normal;
    logic v_doubled;
    logic v_capture;
    logic h_capture;
    logic capture;
    logic frame_start;
    logic [ADDR_BITS-1:0] ptr;
    logic [ADDR_BITS-1:0] addr_cur;
    logic [ADDR_BITS-1:0] ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_next;

    assign wrclock = clock;

    assign x = {20'd0, counterX};
    assign y = {20'd0, counterY};

    assign v_normal  = (y >= V_CAPTURE_START) && (y < V_CAPTURE_END);
    assign v_doubled = (y < FIELD_LINES) || ((y >= FIELD2_START) && (y < V_CAPTURE_END));
    assign v_capture = line_doubler ? v_doubled : v_normal;

    // With decimation only even offsets from the window start are kept.
    assign h_capture = (x >= H_CAPTURE_START) && (x < H_CAPTURE_END) &&
                       (!hdecimate || (counterX[0] == HS_LSB));
    assign capture   = v_capture && h_capture;

    // The first capture line depends on the mode: field mode always begins at line 0.
    assign frame_start = capture && (x == H_CAPTURE_START) &&
                         (y == (line_doubler ? 0 : V_CAPTURE_START));

    always_comb begin
        addr_cur = frame_start ? '0 : ptr;
        ptr_next = (addr_cur == PTR_LAST) ? '0 : addr_cur + 1'b1;
        cnt_cur  = frame_start ? '0 : count;
        cnt_next = (cnt_cur == CNT_MAX) ? CNT_MAX : cnt_cur + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren         <= 1'b0;
            wrdata       <= '0;
            wraddr       <= '0;
            starttrigger <= 1'b0;
            overflow     <= 1'b0;
            ptr          <= '0;
            count        <= '0;
        end else begin
            wren         <= capture;
            starttrigger <= (x == H_CAPTURE_START) && (y == TRIGGER_LINE);
            if (capture) begin
                wrdata <= {R, G, B};
                wraddr <= addr_cur;
                ptr    <= ptr_next;
                count  <= cnt_next;
                if (cnt_next == CNT_OVF) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video2ram_param.sv
// Directed bench for video2ram_param: default instance plus a 1024-deep instance on shared stimulus.
module tb_video2ram_param;

    logic        clock;
    logic        reset;
    logic [7:0]  R, G, B;
    logic [11:0] counterX, counterY;
    logic        line_doubler, hdecimate;

    logic [23:0] wrdata, wrdata_s;
    logic [13:0] wraddr;
    logic [9:0]  wraddr_s;
    logic        wren, wren_s, wrclock, wrclock_s;
    logic        starttrigger, starttrigger_s, overflow, overflow_s;

    int vectors = 0;
    int miscompares = 0;

    video2ram_param dut (
        .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
        .counterX(counterX), .counterY(counterY),
        .line_doubler(line_doubler), .hdecimate(hdecimate),
        .wrdata(wrdata), .wraddr(wraddr), .wren(wren), .wrclock(wrclock),
        .starttrigger(starttrigger), .overflow(overflow)
    );

    video2ram_param #(.ADDR_BITS(10), .DEPTH(1024)) dut_s (
        .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
        .counterX(counterX), .counterY(counterY),
        .line_doubler(line_doubler), .hdecimate(hdecimate),
        .wrdata(wrdata_s), .wraddr(wraddr_s), .wren(wren_s), .wrclock(wrclock_s),
        .starttrigger(starttrigger_s), .overflow(overflow_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] pix(input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        return {xb, yb, xb ^ 8'h5A};
    endfunction

    // Apply a raster position, clock it in, sample just after the edge.
    task automatic tick(input int x, input int y);
        counterX = 12'(x);
        counterY = 12'(y);
        R = counterX[7:0];
        G = counterY[7:0];
        B = counterX[7:0] ^ 8'h5A;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        tick(126, 0);
        tick(127, 0);
        vectors++;
        if (wren !== 1'b0) begin
            miscompares++; $display("FAIL reset wren: got %b want 0", wren);
        end
        vectors++;
        if (wrdata !== 24'h0) begin
            miscompares++; $display("FAIL reset wrdata: got %h want 0", wrdata);
        end
        vectors++;
        if (wraddr !== 14'd0) begin
            miscompares++; $display("FAIL reset wraddr: got %0d want 0", wraddr);
        end
        vectors++;
        if (starttrigger !== 1'b0 || starttrigger_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset starttrigger: got %b/%b want 0", starttrigger, starttrigger_s);
        end
        vectors++;
        if (overflow !== 1'b0 || overflow_s !== 1'b0) begin
            miscompares++; $display("FAIL reset overflow: got %b/%b want 0", overflow, overflow_s);
        end
        vectors++;
        if (wrdata_s !== 24'h0 || wraddr_s !== 10'd0 || wren_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset small: got %h/%0d/%b want 0", wrdata_s, wraddr_s, wren_s);
        end
        vectors++;
        if (wrclock !== clock || wrclock_s !== clock) begin
            miscompares++;
            $display("FAIL wrclock: got %b/%b want %b", wrclock, wrclock_s, clock);
        end
        tick(0, 0);
        reset = 1'b0;
    endtask

    task automatic test_line0;
        int writes = 0;
        logic exp_w;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        for (int x = 120; x <= 770; x++) begin
            tick(x, 0);
            exp_w = (x >= 126) && (x < 766);
            vectors++;
            if (wren !== exp_w) begin
                miscompares++; $display("FAIL line0 wren x=%0d: got %b want %b", x, wren, exp_w);
            end
            if (exp_w) begin
                writes++;
                vectors++;
                if (wraddr !== 14'(x - 126) || wrdata !== pix(x, 0)) begin
                    miscompares++;
                    $display("FAIL line0 write x=%0d: got %0d/%h want %0d/%h",
                             x, wraddr, wrdata, x - 126, pix(x, 0));
                end
            end
            vectors++;
            if (starttrigger !== (x == 126)) begin
                miscompares++;
                $display("FAIL line0 starttrigger x=%0d: got %b want %b", x, starttrigger, x == 126);
            end
        end
        vectors++;
        if (writes != 640) begin
            miscompares++; $display("FAIL line0 write count: got %0d want 640", writes);
        end
        vectors++;
        if (wraddr !== 14'd639 || wrdata !== pix(765, 0)) begin
            miscompares++;
            $display("FAIL line0 hold: got %0d/%h want 639/%h", wraddr, wrdata, pix(765, 0));
        end
    endtask

    task automatic test_hdecimate;
        int writes;
        logic exp_w;
        line_doubler = 1'b0;
        hdecimate = 1'b1;
        for (int line = 0; line < 2; line++) begin
            writes = 0;
            for (int x = 120; x <= 770; x++) begin
                tick(x, line);
                exp_w = (x >= 126) && (x < 766) && ((x - 126) % 2 == 0);
                vectors++;
                if (wren !== exp_w) begin
                    miscompares++;
                    $display("FAIL hdec wren y=%0d x=%0d: got %b want %b", line, x, wren, exp_w);
                end
                if (exp_w) begin
                    writes++;
                    vectors++;
                    if (wraddr !== 14'(line * 320 + (x - 126) / 2)) begin
                        miscompares++;
                        $display("FAIL hdec wraddr y=%0d x=%0d: got %0d want %0d",
                                 line, x, wraddr, line * 320 + (x - 126) / 2);
                    end
                end
            end
            vectors++;
            if (writes != 320) begin
                miscompares++;
                $display("FAIL hdec count y=%0d: got %0d want 320", line, writes);
            end
        end
        hdecimate = 1'b0;
    endtask

    task automatic test_line_doubler;
        int writes = 0;
        line_doubler = 1'b1;
        hdecimate = 1'b0;
        for (int x = 120; x <= 770; x++) tick(x, 0);
        vectors++;
        if (wraddr !== 14'd639) begin
            miscompares++; $display("FAIL ldbl line0 end: got %0d want 639", wraddr);
        end
        for (int i = 0; i < 4; i++) begin
            tick(126 + i, 239);
            vectors++;
            if (wren !== 1'b1 || wraddr !== 14'(640 + i)) begin
                miscompares++;
                $display("FAIL ldbl y239 x=%0d: got %b/%0d want 1/%0d", 126 + i, wren, wraddr, 640 + i);
            end
        end
        for (int x = 120; x <= 770; x++) begin
            tick(x, 240); if (wren) writes++;
            tick(x, 250); if (wren) writes++;
            tick(x, 262); if (wren) writes++;
        end
        vectors++;
        if (writes != 0) begin
            miscompares++; $display("FAIL ldbl gap writes: got %0d want 0", writes);
        end
        tick(126, 263);
        vectors++;
        if (wren !== 1'b1 || wraddr !== 14'd644) begin
            miscompares++; $display("FAIL ldbl y263: got %b/%0d want 1/644", wren, wraddr);
        end
        tick(127, 263);
        tick(126, 479);
        vectors++;
        if (wren !== 1'b1 || wraddr !== 14'd646) begin
            miscompares++; $display("FAIL ldbl y479: got %b/%0d want 1/646", wren, wraddr);
        end
        tick(126, 480);
        vectors++;
        if (wren !== 1'b0) begin
            miscompares++; $display("FAIL ldbl y480 wren: got %b want 0", wren);
        end
        // Leaving field mode mid-frame captures line 250 at once and keeps the pointer.
        line_doubler = 1'b0;
        tick(127, 250);
        vectors++;
        if (wren !== 1'b1 || wraddr !== 14'd647) begin
            miscompares++; $display("FAIL mode switch: got %b/%0d want 1/647", wren, wraddr);
        end
    endtask

    task automatic test_small_depth;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        for (int x = 120; x <= 770; x++) tick(x, 0);
        for (int x = 120; x <= 770; x++) begin
            tick(x, 1);
            if (x >= 126 && x < 766) begin
                vectors++;
                if (wren_s !== 1'b1 || wraddr_s !== 10'((640 + x - 126) % 1024)) begin
                    miscompares++;
                    $display("FAIL small wraddr x=%0d: got %b/%0d want 1/%0d",
                             x, wren_s, wraddr_s, (640 + x - 126) % 1024);
                end
            end
            if (x == 509) begin
                vectors++;
                if (wraddr_s !== 10'd1023 || overflow_s !== 1'b0) begin
                    miscompares++;
                    $display("FAIL small pre-ovf: got %0d/%b want 1023/0", wraddr_s, overflow_s);
                end
            end
            if (x == 510) begin
                vectors++;
                if (wraddr_s !== 10'd0 || overflow_s !== 1'b1) begin
                    miscompares++;
                    $display("FAIL small ovf: got %0d/%b want 0/1", wraddr_s, overflow_s);
                end
                vectors++;
                if (wraddr !== 14'd1024 || overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL default no-wrap: got %0d/%b want 1024/0", wraddr, overflow);
                end
            end
        end
        vectors++;
        if (overflow_s !== 1'b1) begin
            miscompares++; $display("FAIL small ovf sticky: got %b want 1", overflow_s);
        end
    endtask

    task automatic test_wrap_overflow;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        for (int line = 0; line < 26; line++) begin
            for (int x = 120; x <= 770; x++) begin
                tick(x, line);
                if (line == 25 && x == 509) begin
                    vectors++;
                    if (wraddr !== 14'd16383 || overflow !== 1'b0) begin
                        miscompares++;
                        $display("FAIL wrap pre: got %0d/%b want 16383/0", wraddr, overflow);
                    end
                end
                if (line == 25 && x == 510) begin
                    vectors++;
                    if (wraddr !== 14'd0 || overflow !== 1'b1) begin
                        miscompares++;
                        $display("FAIL wrap ovf: got %0d/%b want 0/1", wraddr, overflow);
                    end
                end
            end
        end
        tick(126, 0);
        vectors++;
        if (overflow !== 1'b1 || wraddr !== 14'd0 || starttrigger !== 1'b1) begin
            miscompares++;
            $display("FAIL new frame: got ovf=%b addr=%0d trig=%b want 1/0/1",
                     overflow, wraddr, starttrigger);
        end
    endtask

    task automatic test_reset_midline;
        int writes = 0;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        for (int x = 120; x < 400; x++) tick(x, 10);
        counterX = 12'd400;
        reset = 1'b1;
        #1;
        vectors++;
        if (wren !== 1'b0 || wraddr !== 14'd0 || wrdata !== 24'h0 ||
            overflow !== 1'b0 || starttrigger !== 1'b0) begin
            miscompares++;
            $display("FAIL async reset: got %b/%0d/%h/%b/%b want all 0",
                     wren, wraddr, wrdata, overflow, starttrigger);
        end
        for (int x = 401; x < 858; x++) tick(x, 10);
        reset = 1'b0;
        for (int x = 0; x < 126; x++) begin
            tick(x, 11);
            if (wren) writes++;
        end
        vectors++;
        if (writes != 0) begin
            miscompares++; $display("FAIL post-reset idle writes: got %0d want 0", writes);
        end
        tick(126, 11);
        vectors++;
        if (wren !== 1'b1 || wraddr !== 14'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL post-reset first: got %b/%0d/%b want 1/0/0", wren, wraddr, overflow);
        end
        tick(127, 11);
        vectors++;
        if (wraddr !== 14'd1 || wrdata !== pix(127, 11)) begin
            miscompares++;
            $display("FAIL post-reset second: got %0d/%h want 1/%h", wraddr, wrdata, pix(127, 11));
        end
    endtask

    initial begin
        reset = 1'b1;
        counterX = '0;
        counterY = '0;
        R = '0;
        G = '0;
        B = '0;
        line_doubler = 1'b0;
        hdecimate = 1'b0;
        test_reset();
        test_line0();
        test_hdecimate();
        test_line_doubler();
        test_small_depth();
        test_wrap_overflow();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
